// File: rtl/ss_stream_controller_if.sv
// ss_stream_controller_if: save/load stream handshakes plus the cpu_6s46
// savestate bus, bundled so the controller and its peers share one port.
// The master modport is the controller side.
interface ss_stream_controller_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  ss_bus_addr;
  logic [31:0] ss_bus_in;
  logic        ss_bus_wren;
  logic        ss_bus_reset;
  logic [31:0] ss_bus_out;

  modport master (
    output out_data, out_valid, in_ready,
    output ss_bus_addr, ss_bus_in, ss_bus_wren, ss_bus_reset,
    input  out_ready, in_data, in_valid, ss_bus_out
  );

  modport slave (
    input  out_data, out_valid, in_ready,
    input  ss_bus_addr, ss_bus_in, ss_bus_wren, ss_bus_reset,
    output out_ready, in_data, in_valid, ss_bus_out
  );
endinterface

// File: rtl/ss_stream_controller.sv
// ss_stream_controller: pauses the CPU, then streams every savestate word out
// (save) or writes an incoming word stream onto the savestate bus (load).
// Optional feature macro SS_CHECKSUM_EN: appends / checks a 32-bit sum word
// after the data words; without it CHECK is unreachable and load_error is 0.
module ss_stream_controller #(
  parameter int WORD_COUNT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic save_start,
  input  logic load_start,
  input  logic abort,
  input  logic cpu_paused,
  output logic cpu_pause,
  output logic busy,
  output logic done,
  output logic load_error,
  ss_stream_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_SAVE_ADDR, S_SAVE_OUT, S_LOAD_IN, S_LOAD_WR, S_CHECK, S_DONE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(WORD_COUNT - 1);

  state_t      r_state;
  logic        r_mode_load;
  logic [7:0]  r_idx;
  logic        r_out_first;
  logic [31:0] r_out_data;
  logic        r_out_valid;
  logic        r_in_ready;
  logic        r_wren;
  logic        r_cpu_pause;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_addr;
  logic [31:0] r_bus_in;
  logic        r_ss_bus_reset;
`ifdef SS_CHECKSUM_EN
  logic        r_load_error;
  logic [31:0] r_sum;
`endif

  // The bus read data arrives in the first SAVE_OUT cycle, so it is passed
  // straight through then and held from r_out_data for the rest of the stall.
  logic [31:0] w_out_data;
  logic        w_out_hs;
  logic        w_in_hs;
  logic        w_last;
  assign w_out_data = r_out_first ? bus.ss_bus_out : r_out_data;
  assign w_out_hs   = r_out_valid & bus.out_ready;
  assign w_in_hs    = r_in_ready & bus.in_valid;
  assign w_last     = (r_idx == LAST_IDX);

  // Sequencer: state, word counter, stream/bus registers and status pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mode_load <= 1'b0;
      r_idx       <= 8'd0;
      r_out_first <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_wren      <= 1'b0;
      r_cpu_pause <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= 8'd0;
      r_bus_in    <= 32'd0;
`ifdef SS_CHECKSUM_EN
      r_load_error <= 1'b0;
      r_sum        <= 32'd0;
`endif
    end else if (abort && (r_state != S_IDLE)) begin
      r_state     <= S_IDLE;
      r_out_first <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_wren      <= 1'b0;
      r_cpu_pause <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef SS_CHECKSUM_EN
      r_load_error <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_wren <= 1'b0;
`ifdef SS_CHECKSUM_EN
      r_load_error <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (save_start || load_start) begin
            r_mode_load <= ~save_start;  // save wins a tie
            r_state     <= S_PAUSE;
            r_cpu_pause <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (cpu_paused) begin
            r_idx <= 8'd0;
`ifdef SS_CHECKSUM_EN
            r_sum <= 32'd0;
`endif
            if (r_mode_load) begin
              r_state    <= S_LOAD_IN;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= S_SAVE_ADDR;
              r_addr  <= 8'd0;
            end
          end
        end
        S_SAVE_ADDR: begin
          r_state     <= S_SAVE_OUT;
          r_out_valid <= 1'b1;
          r_out_first <= 1'b1;
        end
        S_SAVE_OUT: begin
          r_out_first <= 1'b0;
          if (r_out_first) r_out_data <= bus.ss_bus_out;
          if (w_out_hs) begin
`ifdef SS_CHECKSUM_EN
            r_sum <= r_sum + w_out_data;
`endif
            if (w_last) begin
`ifdef SS_CHECKSUM_EN
              r_state    <= S_CHECK;
              r_out_data <= r_sum + w_out_data;  // valid stays high
`else
              r_state     <= S_DONE;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
`endif
            end else begin
              r_state     <= S_SAVE_ADDR;
              r_out_valid <= 1'b0;
              r_idx       <= r_idx + 8'd1;
              r_addr      <= r_idx + 8'd1;
            end
          end
        end
        S_LOAD_IN: begin
          if (w_in_hs) begin
            r_state    <= S_LOAD_WR;
            r_in_ready <= 1'b0;
            r_bus_in   <= bus.in_data;
            r_addr     <= r_idx;
            r_wren     <= 1'b1;
`ifdef SS_CHECKSUM_EN
            r_sum <= r_sum + bus.in_data;
`endif
          end
        end
        S_LOAD_WR: begin
          if (w_last) begin
`ifdef SS_CHECKSUM_EN
            r_state    <= S_CHECK;
            r_in_ready <= 1'b1;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
`endif
          end else begin
            r_state    <= S_LOAD_IN;
            r_in_ready <= 1'b1;
            r_idx      <= r_idx + 8'd1;
          end
        end
`ifdef SS_CHECKSUM_EN
        S_CHECK: begin
          if (r_mode_load) begin
            if (w_in_hs) begin
              r_state      <= S_DONE;
              r_in_ready   <= 1'b0;
              r_done       <= 1'b1;
              r_load_error <= (bus.in_data != r_sum);
            end
          end else if (w_out_hs) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cpu_pause <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Savestate bus reset follows system reset one cycle later.
  always_ff @(posedge clk) begin
    r_ss_bus_reset <= ~reset;
  end

  assign cpu_pause        = r_cpu_pause;
  assign busy             = r_busy;
  assign done             = r_done;
`ifdef SS_CHECKSUM_EN
  assign load_error       = r_load_error;
`else
  assign load_error       = 1'b0;
`endif
  assign bus.out_data     = w_out_data;
  assign bus.out_valid    = r_out_valid;
  assign bus.in_ready     = r_in_ready;
  assign bus.ss_bus_addr  = r_addr;
  assign bus.ss_bus_in    = r_bus_in;
  assign bus.ss_bus_wren  = r_wren;
  assign bus.ss_bus_reset = r_ss_bus_reset;

endmodule

// File: tb/tb_ss_stream_controller.sv
// tb_ss_stream_controller: table-driven and randomized save/load runs checked
// against a word-list reference model, plus abort/reset/start-priority cases.
module tb_ss_stream_controller;
  localparam int N = 4;
`ifdef SS_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic save_start = 1'b0, load_start = 1'b0, abort = 1'b0, cpu_paused = 1'b0;
  logic cpu_pause, busy, done, load_error;

  always #5 clk = ~clk;

  ss_stream_controller_if ssif ();

  ss_stream_controller #(.WORD_COUNT(N)) dut (
    .clk(clk), .reset(reset), .save_start(save_start), .load_start(load_start),
    .abort(abort), .cpu_paused(cpu_paused), .cpu_pause(cpu_pause), .busy(busy),
    .done(done), .load_error(load_error), .bus(ssif)
  );

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- environment models ----------------
  logic [31:0] mem [0:255];
  always @(posedge clk) ssif.ss_bus_out <= mem[ssif.ss_bus_addr];

  int pcnt = 0;
  always @(posedge clk) begin
    if (!cpu_pause) begin pcnt <= 0; cpu_paused <= 1'b0; end
    else if (pcnt == 2) cpu_paused <= 1'b1;
    else pcnt <= pcnt + 1;
  end

  int rmode = 0, vmode = 0;
  always begin
    @(posedge clk); #1;
    case (rmode)
      0: ssif.out_ready = 1'b1;
      1: ssif.out_ready = ~ssif.out_ready;
      2: ssif.out_ready = ($urandom_range(0, 1) == 1);
      4: ssif.out_ready = 1'b0;
      default: ;
    endcase
  end

  logic [31:0] in_q[$];
  bit hs_in = 0;
  always begin
    @(posedge clk); #1;
    if (hs_in) begin
      if (in_q.size() > 0) void'(in_q.pop_front());
      hs_in = 0;
      ssif.in_valid = 1'b0;
    end
    if (!ssif.in_valid && in_q.size() > 0 && (vmode == 0 || $urandom_range(0, 1) == 1)) begin
      ssif.in_valid = 1'b1;
      ssif.in_data  = in_q[0];
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] got_out[$];
  logic [39:0] got_wr[$];
  logic [31:0] exp_stream[$];
  bit stream_chk = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, t_paused = 0, t_done = 0;
  bit paused_seen = 0;
  logic err_at_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (stream_chk && ssif.out_valid === 1'b1 && got_out.size() < exp_stream.size())
      chk("out_data", ssif.out_data, exp_stream[got_out.size()]);
    if (ssif.out_valid === 1'b1 && ssif.out_ready === 1'b1) got_out.push_back(ssif.out_data);
    if (ssif.ss_bus_wren === 1'b1) begin
      got_wr.push_back({ssif.ss_bus_addr, ssif.ss_bus_in});
      chk("in_ready_vs_wren", {31'd0, ssif.in_ready}, 32'd0);
    end
    if (ssif.in_valid === 1'b1 && ssif.in_ready === 1'b1) hs_in = 1;
    if (done === 1'b1) begin done_cnt++; t_done = cyc; err_at_done = load_error; end
    if (load_error === 1'b1) err_cnt++;
    if (cpu_paused && busy === 1'b1 && !paused_seen) begin paused_seen = 1; t_paused = cyc; end
  end

  // ---------------- helpers ----------------
  logic [31:0] dat [N];

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic pulse_start(input bit s, input bit l);
    save_start = s; load_start = l; tick(); save_start = 0; load_start = 0;
  endtask

  task automatic clear_logs();
    got_out.delete(); got_wr.delete();
    done_cnt = 0; err_cnt = 0; paused_seen = 0; err_at_done = 1'b0;
  endtask

  task automatic prep_save();
    logic [31:0] s = 32'd0;
    exp_stream.delete();
    for (int i = 0; i < N; i++) begin mem[i] = dat[i]; exp_stream.push_back(dat[i]); s += dat[i]; end
    if (CK == 1) exp_stream.push_back(s);
  endtask

  task automatic prep_load(input bit bad);
    logic [31:0] s = 32'd0;
    in_q.delete();
    for (int i = 0; i < N; i++) begin in_q.push_back(dat[i]); s += dat[i]; end
    if (CK == 1) in_q.push_back(bad ? ((s == 32'd0) ? 32'd1 : 32'd0) : s);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (done_cnt == 0 && k < 500) begin tick(); k++; end
    if (done_cnt == 0) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
      reset = 0; tick(); tick(); reset = 1;
    end
    repeat (3) tick();
  endtask

  task automatic run_op(input string nm, input bit op, input int rm, input int vm,
                        input bit bad, input bit exp_err);
    clear_logs();
    rmode = rm; vmode = vm;
    if (!op) begin prep_save(); stream_chk = 1; end
    else prep_load(bad);
    pulse_start(!op, op);
    wait_done(nm);
    stream_chk = 0;
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_err_cnt"}, err_cnt, {31'd0, exp_err});
    chk({nm, "_err_at_done"}, {31'd0, err_at_done}, {31'd0, exp_err});
    if (!op) begin
      chk({nm, "_nwords"}, got_out.size(), N + CK);
      for (int i = 0; i < N + CK && i < got_out.size(); i++)
        chk($sformatf("%s_word%0d", nm, i), got_out[i], exp_stream[i]);
      chk({nm, "_nwrites"}, got_wr.size(), 0);
    end else begin
      chk({nm, "_nwrites"}, got_wr.size(), N);
      for (int i = 0; i < N && i < got_wr.size(); i++) begin
        chk($sformatf("%s_addr%0d", nm, i), {24'd0, got_wr[i][39:32]}, i);
        chk($sformatf("%s_data%0d", nm, i), got_wr[i][31:0], dat[i]);
      end
      chk({nm, "_nwords"}, got_out.size(), 0);
    end
    if ((!op && rm == 0) || (op && vm == 0))
      chk({nm, "_latency"}, t_done - t_paused, 2 * N + 1 + CK);
    chk({nm, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({nm, "_pause_end"}, {31'd0, cpu_pause}, 32'd0);
    $display("[TB] %s op=%0d rmode=%0d vmode=%0d words=%0d writes=%0d", nm, op, rm, vm,
             got_out.size(), got_wr.size());
    rmode = 0; vmode = 0; in_q.delete();
  endtask

  typedef struct {
    string       nm;
    bit          op;
    int          rm;
    int          vm;
    logic [31:0] base;
    logic [31:0] step;
    bit          bad;
    bit          exp_err;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int k;
    tbl[0] = '{"save_plain",  1'b0, 0, 0, 32'hA0000000, 32'd1,     1'b0, 1'b0};
    tbl[1] = '{"save_toggle", 1'b0, 1, 0, 32'hA0000000, 32'd1,     1'b0, 1'b0};
    tbl[2] = '{"save_rand",   1'b0, 2, 0, 32'hFFFFFFF0, 32'h9,     1'b0, 1'b0};
    tbl[3] = '{"load_plain",  1'b1, 0, 0, 32'h11,       32'h11,    1'b0, 1'b0};
    tbl[4] = '{"load_gapped", 1'b1, 0, 1, 32'h11,       32'h11,    1'b0, 1'b0};
    tbl[5] = '{"load_badck",  1'b1, 0, 1, 32'h11,       32'h11,    1'b1, (CK == 1)};

    ssif.out_ready = 1'b0; ssif.in_valid = 1'b0; ssif.in_data = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    // reset values
    repeat (3) tick();
    chk("rst_cpu_pause", {31'd0, cpu_pause}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_load_error", {31'd0, load_error}, 0);
    chk("rst_out_valid", {31'd0, ssif.out_valid}, 0);
    chk("rst_in_ready", {31'd0, ssif.in_ready}, 0);
    chk("rst_wren", {31'd0, ssif.ss_bus_wren}, 0);
    chk("rst_out_data", ssif.out_data, 0);
    chk("rst_addr", {24'd0, ssif.ss_bus_addr}, 0);
    chk("rst_bus_in", ssif.ss_bus_in, 0);
    chk("rst_ss_bus_reset", {31'd0, ssif.ss_bus_reset}, 1);
    reset = 1; tick();
    chk("rel_ss_bus_reset", {31'd0, ssif.ss_bus_reset}, 0);
    tick();

    // table-driven vectors
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) dat[i] = tbl[t].base + tbl[t].step * i;
      run_op(tbl[t].nm, tbl[t].op, tbl[t].rm, tbl[t].vm, tbl[t].bad, tbl[t].exp_err);
    end

    // randomized runs against the word-list model
    for (int r = 0; r < 8; r++) begin
      bit op, bad;
      op  = ($urandom_range(0, 1) == 1);
      bad = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) dat[i] = $urandom;
      run_op($sformatf("rand%0d", r), op, $urandom_range(0, 2), $urandom_range(0, 1),
             bad, bad && (CK == 1));
    end

    // both starts together, then a load_start during the save
    clear_logs();
    for (int i = 0; i < N; i++) dat[i] = 32'hC0 + i;
    prep_save(); stream_chk = 1; rmode = 0;
    pulse_start(1, 1);
    repeat (3) tick();
    pulse_start(0, 1);
    wait_done("both_start");
    stream_chk = 0;
    repeat (4) tick();
    chk("both_nwords", got_out.size(), N + CK);
    chk("both_nwrites", got_wr.size(), 0);
    chk("both_done_cnt", done_cnt, 1);
    chk("both_busy_after", {31'd0, busy}, 0);
    $display("[TB] both_start words=%0d writes=%0d", got_out.size(), got_wr.size());

    // abort while the third save word is stalled
    clear_logs();
    for (int i = 0; i < N; i++) dat[i] = $urandom;
    prep_save(); stream_chk = 1; rmode = 0;
    pulse_start(1, 0);
    k = 0;
    while (got_out.size() < 2 && k < 100) begin tick(); k++; end
    rmode = 5; ssif.out_ready = 1'b0;
    k = 0;
    while (ssif.out_valid !== 1'b1 && k < 10) begin tick(); k++; end
    chk("abort_third_valid", {31'd0, ssif.out_valid}, 1);
    abort = 1; tick(); abort = 0;
    chk("abort_out_valid", {31'd0, ssif.out_valid}, 0);
    chk("abort_cpu_pause", {31'd0, cpu_pause}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    repeat (6) tick();
    stream_chk = 0;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_nwords", got_out.size(), 2);
    $display("[TB] abort words=%0d done=%0d", got_out.size(), done_cnt);
    rmode = 0; tick();

    // reset during LOAD_WR of the second word
    clear_logs();
    for (int i = 0; i < N; i++) dat[i] = 32'h5A000000 + i;
    prep_load(0); vmode = 0;
    pulse_start(0, 1);
    k = 0;
    while (!(ssif.ss_bus_wren === 1'b1 && ssif.ss_bus_addr == 8'd1) && k < 100) begin tick(); k++; end
    chk("rstwr_reached", {31'd0, ssif.ss_bus_wren}, 1);
    reset = 0; tick();
    in_q.delete(); ssif.in_valid = 1'b0; hs_in = 0;
    chk("rstwr_wren", {31'd0, ssif.ss_bus_wren}, 0);
    chk("rstwr_in_ready", {31'd0, ssif.in_ready}, 0);
    chk("rstwr_busy", {31'd0, busy}, 0);
    chk("rstwr_cpu_pause", {31'd0, cpu_pause}, 0);
    chk("rstwr_done", {31'd0, done}, 0);
    chk("rstwr_addr", {24'd0, ssif.ss_bus_addr}, 0);
    chk("rstwr_bus_in", ssif.ss_bus_in, 0);
    chk("rstwr_out_data", ssif.out_data, 0);
    chk("rstwr_ss_bus_reset", {31'd0, ssif.ss_bus_reset}, 1);
    reset = 1; repeat (3) tick();
    chk("rstwr_no_done", done_cnt, 0);
    $display("[TB] reset_in_load writes=%0d", got_wr.size());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
